// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared back-end constants and pointer types for the FE queue
package bp_be_pkg;

    localparam int bp_be_fe_queue_els_gp = 8;

    // Extra MSB is the wrap bit that tells full apart from empty.
    function automatic int bp_be_ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

    localparam int bp_be_fe_queue_ptr_width_gp = bp_be_ptr_width(bp_be_fe_queue_els_gp);

    typedef struct packed {
        logic                                   wrap;
        logic [bp_be_fe_queue_ptr_width_gp-2:0] idx;
    } bp_be_fe_queue_ptr_s;

endpackage

// File: rtl/bp_be_fe_queue_ptr.sv
// rtl/bp_be_fe_queue_ptr.sv - wrapping up-counter with load, used for queue pointers
module bp_be_fe_queue_ptr #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               inc_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    output logic [width_p-1:0] ptr_o
);

    // Load wins over increment so rollback/clear override a same-cycle advance.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_o <= '0;
        end else if (load_i) begin
            ptr_o <= load_val_i;
        end else if (inc_i) begin
            ptr_o <= ptr_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bp_be_fe_queue_rollback.sv
// rtl/bp_be_fe_queue_rollback.sv - speculative FE queue with commit/rollback/clear; optional BP_BE_FE_QUEUE_BYPASS_EN
module bp_be_fe_queue_rollback
    import bp_be_pkg::*;
#(
    parameter int els_p        = bp_be_fe_queue_els_gp,
    parameter int data_width_p = 128,
    localparam int ptr_width_lp = bp_be_ptr_width(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [data_width_p-1:0] fe_queue_i,
    input  logic                    fe_queue_v_i,
    output logic                    fe_queue_ready_o,
    output logic [data_width_p-1:0] fe_queue_o,
    output logic                    fe_queue_v_o,
    input  logic                    fe_queue_yumi_i,
    input  logic                    fe_queue_deq_i,
    input  logic                    fe_queue_roll_i,
    input  logic                    fe_queue_clr_i,
    output logic                    empty_o,
    output logic [ptr_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_next, rptr_load_val;
    logic [data_width_p-1:0] mem [els_p];
    logic                    full, enq, stored_v, yumi_fire;

    assign count_o          = wptr - cptr;
    assign empty_o          = (cptr == wptr);
    assign full             = (count_o == ptr_width_lp'(els_p));
    assign fe_queue_ready_o = ~full & reset_n_i;
    assign enq              = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;
    assign stored_v         = (rptr != wptr);

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass       = ~stored_v & enq;
    assign fe_queue_v_o = stored_v | bypass;
    assign fe_queue_o   = bypass ? fe_queue_i : mem[rptr[ptr_width_lp-2:0]];
`else
    assign fe_queue_v_o = stored_v;
    assign fe_queue_o   = mem[rptr[ptr_width_lp-2:0]];
`endif

    assign yumi_fire     = fe_queue_yumi_i & fe_queue_v_o;
    // Rollback target includes a same-cycle commit.
    assign cptr_next     = cptr + ptr_width_lp'(fe_queue_deq_i);
    assign rptr_load_val = fe_queue_clr_i ? wptr : cptr_next;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr[ptr_width_lp-2:0]] <= fe_queue_i;
        end
    end

    bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) wptr_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (enq),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (wptr)
    );

    bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) rptr_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (yumi_fire),
        .load_i     (fe_queue_clr_i | fe_queue_roll_i),
        .load_val_i (rptr_load_val),
        .ptr_o      (rptr)
    );

    bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) cptr_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (fe_queue_deq_i),
        .load_i     (fe_queue_clr_i),
        .load_val_i (wptr),
        .ptr_o      (cptr)
    );

`ifndef SYNTHESIS
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fe_queue_yumi_i |-> fe_queue_v_o);
    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fe_queue_deq_i |-> (cptr != rptr));
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_rollback.sv
// tb/tb_bp_be_fe_queue_rollback.sv - randomized model-based bench for the speculative FE queue
module tb_bp_be_fe_queue_rollback;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] fe_in;
    logic         fe_v_in;
    logic         ready;
    logic [127:0] fe_out;
    logic         fe_v_out;
    logic         yumi, deq, roll, clr;
    logic         empty;
    logic [3:0]   count;

    int tests = 0;
    int fails = 0;

    // Model: held entries oldest first; mr = how many of them have been read.
    logic [127:0] mq[$];
    int           mr;

    always #5 clk = ~clk;

    bp_be_fe_queue_rollback dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .fe_queue_i       (fe_in),
        .fe_queue_v_i     (fe_v_in),
        .fe_queue_ready_o (ready),
        .fe_queue_o       (fe_out),
        .fe_queue_v_o     (fe_v_out),
        .fe_queue_yumi_i  (yumi),
        .fe_queue_deq_i   (deq),
        .fe_queue_roll_i  (roll),
        .fe_queue_clr_i   (clr),
        .empty_o          (empty),
        .count_o          (count)
    );

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic cyc(input bit v, input logic [127:0] d, input bit y, input bit dq,
                       input bit rl, input bit cl);
        bit enq_f, yumi_f;
        fe_v_in = v; fe_in = d; yumi = y; deq = dq; roll = rl; clr = cl;
        enq_f  = v && (mq.size() < 8) && !cl;
        yumi_f = y && (mr < mq.size());
        @(posedge clk);
        if (cl) begin
            mq.delete();
            mr = 0;
        end else begin
            if (dq) begin
                void'(mq.pop_front());
                mr--;
            end
            if (rl) mr = 0;
            else if (yumi_f) mr++;
            if (enq_f) mq.push_back(d);
        end
        @(negedge clk);
        fe_v_in = 0; yumi = 0; deq = 0; roll = 0; clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; fe_v_in = 0; fe_in = '0; yumi = 0; deq = 0; roll = 0; clr = 0;
        mq.delete(); mr = 0;
        repeat (3) @(negedge clk);
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_reset got=%b exp=0", ready); end
        tests++; if (fe_v_out !== 1'b0) begin fails++; $display("FAIL reset_v got=%b exp=0", fe_v_out); end
        rst_n = 1;
        #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after got=%b exp=1", ready); end
        tests++; if (empty !== 1'b1 || count !== 4'd0) begin
            fails++; $display("FAIL reset_empty_count got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) cyc(1, 128'(i), 0, 0, 0, 0);
        tests++; if (ready !== 1'b0 || count !== 4'd8) begin
            fails++; $display("FAIL fill_full got ready=%b count=%0d exp 0/8", ready, count); end
        cyc(1, 128'h9, 0, 0, 0, 0);
        tests++; if (count !== 4'd8 || fe_out !== 128'h1) begin
            fails++; $display("FAIL fill_ninth_dropped got count=%0d head=%h exp 8/1", count, fe_out); end
    endtask

    task automatic test_read_commit();
        for (int i = 1; i <= 3; i++) begin
            tests++; if (fe_v_out !== 1'b1 || fe_out !== 128'(i)) begin
                fails++; $display("FAIL read_data got v=%b d=%h exp 1/%h", fe_v_out, fe_out, 128'(i)); end
            cyc(0, '0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0, 0);
        tests++; if (count !== 4'd5 || fe_out !== 128'h4 || ready !== 1'b1) begin
            fails++; $display("FAIL commit_state got count=%0d d=%h ready=%b exp 5/4/1", count, fe_out, ready); end
    endtask

    task automatic test_rollback();
        cyc(0, '0, 1, 0, 0, 0);
        cyc(0, '0, 1, 0, 0, 0);
        tests++; if (fe_out !== 128'h6) begin fails++; $display("FAIL roll_pre got=%h exp=6", fe_out); end
        cyc(0, '0, 0, 0, 1, 0);
        tests++; if (fe_out !== 128'h4 || count !== 4'd5) begin
            fails++; $display("FAIL roll_rewind got d=%h count=%0d exp 4/5", fe_out, count); end
        cyc(0, '0, 1, 0, 0, 0);
        cyc(0, '0, 0, 1, 1, 0);
        tests++; if (fe_out !== 128'h5 || count !== 4'd4) begin
            fails++; $display("FAIL roll_deq got d=%h count=%0d exp 5/4", fe_out, count); end
    endtask

    task automatic test_clear();
        cyc(1, 128'hA, 0, 0, 0, 1);
        tests++; if (empty !== 1'b1 || fe_v_out !== 1'b0 || count !== 4'd0) begin
            fails++; $display("FAIL clear_state got empty=%b v=%b count=%0d exp 1/0/0", empty, fe_v_out, count); end
        cyc(1, 128'hB, 0, 0, 0, 0);
        tests++; if (fe_v_out !== 1'b1 || fe_out !== 128'hB || count !== 4'd1) begin
            fails++; $display("FAIL clear_no_stale got v=%b d=%h count=%0d exp 1/b/1", fe_v_out, fe_out, count); end
        cyc(0, '0, 0, 0, 0, 1);
    endtask

    task automatic test_wrap();
        int sent = 0, got = 0, cycles = 0;
        bit v, y, accept;
        while (got < 40 && cycles < 400) begin
            v = (sent < 40);
            accept = v && (mq.size() < 8);
            y = fe_v_out;
            if (y) begin
                tests++; if (fe_out !== 128'(got + 32'h100)) begin
                    fails++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", got, fe_out, 128'(got + 32'h100)); end
                got++;
            end
            cyc(v, 128'(sent + 32'h100), y, mr > 0, 0, 0);
            if (accept) sent++;
            cycles++;
        end
        tests++; if (got != 40) begin fails++; $display("FAIL wrap_timeout got=%0d exp=40", got); end
        while (mr > 0) cyc(0, '0, 0, 1, 0, 0);
        tests++; if (empty !== 1'b1 || count !== 4'd0) begin
            fails++; $display("FAIL wrap_drain got empty=%b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_random();
        bit v, y, dq, rl, cl;
        for (int i = 0; i < 400; i++) begin
            tests++; if (fe_v_out !== (mr < mq.size())) begin
                fails++; $display("FAIL rand_v cyc=%0d got=%b exp=%b", i, fe_v_out, mr < mq.size()); end
            if (mr < mq.size()) begin
                tests++; if (fe_out !== mq[mr]) begin
                    fails++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, fe_out, mq[mr]); end
            end
            tests++; if (ready !== (mq.size() < 8) || count !== 4'(mq.size()) || empty !== (mq.size() == 0)) begin
                fails++; $display("FAIL rand_state cyc=%0d got ready=%b count=%0d empty=%b exp count=%0d",
                                  i, ready, count, empty, mq.size()); end
            v  = ($urandom_range(0, 2) != 0);
            y  = (mr < mq.size()) && ($urandom_range(0, 1) == 1);
            dq = (mr > 0) && ($urandom_range(0, 2) == 0);
            rl = ($urandom_range(0, 11) == 0);
            cl = ($urandom_range(0, 29) == 0);
            cyc(v, rnd128(), y, dq, rl, cl);
        end
    endtask

    task automatic test_async_reset();
        cyc(0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, rnd128(), 0, 0, 0, 0);
        tests++; if (count !== 4'd5) begin fails++; $display("FAIL areset_pre got=%0d exp=5", count); end
        #2 rst_n = 0;
        #1;
        tests++; if (fe_v_out !== 1'b0 || ready !== 1'b0 || empty !== 1'b1 || count !== 4'd0) begin
            fails++; $display("FAIL areset_immediate got v=%b ready=%b empty=%b count=%0d exp 0/0/1/0",
                              fe_v_out, ready, empty, count); end
        mq.delete(); mr = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        tests++; if (ready !== 1'b1 || fe_v_out !== 1'b0) begin
            fails++; $display("FAIL areset_release got ready=%b v=%b exp 1/0", ready, fe_v_out); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_commit();
        test_rollback();
        test_clear();
        test_wrap();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
